pe_input_scheduler: RTL and testbench
=====================================

// Module: pe_input_scheduler
// PURPOSE
//  Sequences one feature-map frame into the PE input pre-data stage, which packs 26 bytes into a 208-bit vector.
//  Fetches bytes from a source stream, inserts left/right zero padding per row, and zero-fills the last partial vector.
//  After each full vector it stalls until the pre-data stage acknowledges it with dout_vld.
// PARAMETERS
//  DW         8   data byte width
//  VEC_BYTES  26  bytes per parallel vector (VEC_BYTES*DW = 208)
//  COL_W      8   width of column config/counter
//  ROW_W      8   width of row config/counter
// PORTS
//  din_clk       in   1           sole clock, rising edge
//  rst_n         in   1           async active-low reset
//  en            in   1           global enable; low freezes all state
//  start         in   1           frame start pulse, sampled in IDLE only
//  cfg_cols      in   COL_W       data bytes per row
//  cfg_rows      in   ROW_W       rows per frame
//  cfg_pad       in   8           [7:4] left pad bytes, [3:0] right pad bytes
//  src_data      in   DW          source byte
//  src_vld       in   1           source byte valid
//  src_rdy       out  1           scheduler accepts src_data this cycle
//  o_data_din    out  DW          byte to pre-data stage
//  o_data_din_vld out 1           o_data_din valid
//  pe_dout_vld   in   1           vector-accepted pulse from pre-data stage
//  busy          out  1           frame in progress
//  row_done      out  1           1-cycle pulse after last right-pad byte of a row
//  frame_done    out  1           1-cycle pulse at end of frame
// BEHAVIOUR
//  Reset: state=IDLE; src_rdy, o_data_din_vld, busy, row_done, frame_done=0; o_data_din=0; counters=0.
//  Outputs are registered; o_data_din/o_data_din_vld change one cycle after a byte is chosen.
//  FSM: IDLE -> PAD_L -> DATA -> PAD_R -> (next row PAD_L | FLUSH | WAIT_PE) ; FLUSH -> WAIT_PE -> DONE -> IDLE.
//  IDLE: on start&en, latch cfg_*; if cfg_rows==0 or cfg_cols==0 go DONE without emitting; else PAD_L, busy=1.
//  PAD_L/PAD_R: emit one 0 byte per cycle, count = cfg_pad nibble; nibble 0 skips state in zero cycles.
//  DATA: src_rdy=1 when not awaiting vector ack; byte emitted only on src_vld&src_rdy; src_vld=0 -> bubble, no vld.
//  Vector count vb counts emitted bytes mod VEC_BYTES; on emitting byte VEC_BYTES-1 enter WAIT_PE after that byte,
//   recording return state; src_rdy=0 and no bytes emitted while in WAIT_PE.
//  WAIT_PE: exit on pe_dout_vld (return state or DONE); pe_dout_vld in any other state is ignored.
//  End of last row's PAD_R: vb!=0 -> FLUSH emits VEC_BYTES-vb zero bytes then WAIT_PE; vb==0 -> DONE directly
//   (if the last byte filled a vector, WAIT_PE is taken first, then DONE).
//  DONE: frame_done=1 for one cycle, busy=0, return IDLE.
//  en=0: no state/counter change, src_rdy=0, o_data_din_vld=0, pulses suppressed; resumes exactly where held.
//  start while busy: ignored. cfg_* changes mid-frame: ignored (latched copy used).
//  Async reset mid-frame: immediate return to reset values; partial vector abandoned.
//  Bytes per row = padL+cols+padR; total frame bytes rounded up to multiple of VEC_BYTES.
// CONFIGURATION
//  SCHED_STATS_EN defined: adds output stall_cnt[15:0], counts DATA cycles with src_rdy&!src_vld plus WAIT_PE
//   cycles; clears on start accepted; saturates at 16'hFFFF; reset 0.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  T1 rows=1 cols=24 pad=8'h11, src_vld=1 -> 26 bytes: 00, 24 src, 00; WAIT_PE; pe_dout_vld -> frame_done.
//  T2 rows=2 cols=10 pad=8'h21 -> 26 bytes then WAIT_PE stall (src_rdy=0), 0 remainder after row2 -> frame_done.
//  T3 rows=1 cols=5 pad=8'h00 -> 5 data + 21 FLUSH zeros, exactly 26 vld bytes, WAIT_PE, frame_done.
//  T4 toggle src_vld 1/0 and en low 3 cycles mid-DATA -> byte order unchanged, no duplicate/lost bytes.
//  T5 rows=0 -> frame_done 2 cycles after start, zero o_data_din_vld; start while busy -> no effect.
//  T6 assert rst_n=0 mid-DATA -> all outputs 0 immediately; new start runs T1 cleanly.

Source files
------------

// File: rtl/pe_input_scheduler.sv
// pe_input_scheduler: turns one feature-map frame into left/right zero-padded rows, grouped
// into VEC_BYTES-byte vectors that each wait for an acknowledge. `SCHED_STATS_EN adds stall_cnt.
module pe_input_scheduler #(
  parameter int DW        = 8,
  parameter int VEC_BYTES = 26,
  parameter int COL_W     = 8,
  parameter int ROW_W     = 8
) (
  input  logic             din_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [COL_W-1:0] cfg_cols,
  input  logic [ROW_W-1:0] cfg_rows,
  input  logic [7:0]       cfg_pad,
  input  logic [DW-1:0]    src_data,
  input  logic             src_vld,
  output logic             src_rdy,
  output logic [DW-1:0]    o_data_din,
  output logic             o_data_din_vld,
  input  logic             pe_dout_vld,
  output logic             busy,
  output logic             row_done,
`ifdef SCHED_STATS_EN
  output logic [15:0]      stall_cnt,
`endif
  output logic             frame_done
);

  localparam int VB_W = $clog2(VEC_BYTES);
  localparam logic [VB_W-1:0] VB_LAST = VB_W'(VEC_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAD_L,
    S_DATA,
    S_PAD_R,
    S_FLUSH,
    S_WAIT_PE,
    S_DONE
  } state_t;

  state_t           state;
  state_t           ret_state;
  logic [COL_W-1:0] cols_q;
  logic [ROW_W-1:0] rows_q;
  logic [3:0]       padl_q;
  logic [3:0]       padr_q;
  logic [ROW_W-1:0] row_cnt;
  logic [COL_W-1:0] col_cnt;
  logic [3:0]       pad_cnt;
  logic [VB_W-1:0]  vb;

  logic row_last;
  logic col_last;
  logic padl_last;
  logic padr_last;

  assign row_last  = (row_cnt == rows_q - ROW_W'(1));
  assign col_last  = (col_cnt == cols_q - COL_W'(1));
  assign padl_last = (pad_cnt == padl_q - 4'd1);
  assign padr_last = (pad_cnt == padr_q - 4'd1);

  // src_rdy is a decode of the state register, so it drops the same cycle en does
  assign src_rdy = en && (state == S_DATA);

  state_t          row_start;
  state_t          row_end_next;
  state_t          target;
  logic            emit;
  logic            row_end;
  logic            fill;
  logic [DW-1:0]   emit_byte;

  // Where the current state goes after its byte; a zero pad nibble skips that state entirely
  always_comb begin
    row_start    = (padl_q != 4'd0) ? S_PAD_L : S_DATA;
    row_end_next = row_last ? S_FLUSH : row_start;
    emit         = 1'b0;
    emit_byte    = '0;
    target       = state;
    row_end      = 1'b0;
    case (state)
      S_PAD_L: begin
        emit   = 1'b1;
        target = padl_last ? S_DATA : S_PAD_L;
      end
      S_DATA: begin
        if (src_vld) begin
          emit      = 1'b1;
          emit_byte = src_data;
          if (col_last) begin
            if (padr_q != 4'd0) begin
              target = S_PAD_R;
            end else begin
              target  = row_end_next;
              row_end = 1'b1;
            end
          end
        end
      end
      S_PAD_R: begin
        emit = 1'b1;
        if (padr_last) begin
          target  = row_end_next;
          row_end = 1'b1;
        end
      end
      S_FLUSH: begin
        emit = 1'b1;
      end
      default: ;
    endcase
    fill = emit && (vb == VB_LAST);
  end

  // A byte that completes a vector parks the FSM in WAIT_PE; a pending flush becomes DONE
  // because the vector boundary has just been reached.
  always_ff @(posedge din_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      ret_state      <= S_IDLE;
      cols_q         <= '0;
      rows_q         <= '0;
      padl_q         <= '0;
      padr_q         <= '0;
      row_cnt        <= '0;
      col_cnt        <= '0;
      pad_cnt        <= '0;
      vb             <= '0;
      o_data_din     <= '0;
      o_data_din_vld <= 1'b0;
      busy           <= 1'b0;
      row_done       <= 1'b0;
      frame_done     <= 1'b0;
    end else if (en) begin
      o_data_din_vld <= emit;
      row_done       <= emit && row_end;
      frame_done     <= 1'b0;
      if (emit) begin
        o_data_din <= emit_byte;
        vb         <= fill ? '0 : vb + VB_W'(1);
        if (fill) begin
          state     <= S_WAIT_PE;
          ret_state <= (target == S_FLUSH) ? S_DONE : target;
        end else begin
          state <= target;
        end
        if (row_end && !row_last) begin
          row_cnt <= row_cnt + ROW_W'(1);
        end
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            cols_q  <= cfg_cols;
            rows_q  <= cfg_rows;
            padl_q  <= cfg_pad[7:4];
            padr_q  <= cfg_pad[3:0];
            row_cnt <= '0;
            col_cnt <= '0;
            pad_cnt <= '0;
            vb      <= '0;
            if (cfg_rows == '0 || cfg_cols == '0) begin
              state <= S_DONE;
            end else begin
              state <= (cfg_pad[7:4] != 4'd0) ? S_PAD_L : S_DATA;
              busy  <= 1'b1;
            end
          end
        end
        S_PAD_L: pad_cnt <= padl_last ? 4'd0 : pad_cnt + 4'd1;
        S_DATA: begin
          if (src_vld) begin
            col_cnt <= col_last ? '0 : col_cnt + COL_W'(1);
          end
        end
        S_PAD_R: pad_cnt <= padr_last ? 4'd0 : pad_cnt + 4'd1;
        S_WAIT_PE: begin
          if (pe_dout_vld) begin
            state <= ret_state;
          end
        end
        S_DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: ;
      endcase
    end else begin
      o_data_din_vld <= 1'b0;
      row_done       <= 1'b0;
      frame_done     <= 1'b0;
    end
  end

`ifdef SCHED_STATS_EN
  always_ff @(posedge din_clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (en) begin
      if (state == S_IDLE && start) begin
        stall_cnt <= '0;
      end else if (((state == S_DATA && !src_vld) || state == S_WAIT_PE) &&
                   stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pe_input_scheduler.sv
// Directed self-checking bench for pe_input_scheduler: builds the expected padded byte stream
// for each frame and compares it with what the scheduler emits.
module tb_pe_input_scheduler;

  localparam int VEC = 26;

  logic       din_clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       start;
  logic [7:0] cfg_cols;
  logic [7:0] cfg_rows;
  logic [7:0] cfg_pad;
  logic [7:0] src_data;
  logic       src_vld;
  logic       src_rdy;
  logic [7:0] o_data_din;
  logic       o_data_din_vld;
  logic       pe_dout_vld;
  logic       busy;
  logic       row_done;
  logic       frame_done;
`ifdef SCHED_STATS_EN
  logic [15:0] stall_cnt;
`endif

  pe_input_scheduler dut (
    .din_clk        (din_clk),
    .rst_n          (rst_n),
    .en             (en),
    .start          (start),
    .cfg_cols       (cfg_cols),
    .cfg_rows       (cfg_rows),
    .cfg_pad        (cfg_pad),
    .src_data       (src_data),
    .src_vld        (src_vld),
    .src_rdy        (src_rdy),
    .o_data_din     (o_data_din),
    .o_data_din_vld (o_data_din_vld),
    .pe_dout_vld    (pe_dout_vld),
    .busy           (busy),
    .row_done       (row_done),
`ifdef SCHED_STATS_EN
    .stall_cnt      (stall_cnt),
`endif
    .frame_done     (frame_done)
  );

  always #5 din_clk = ~din_clk;

  int         num_checks = 0;
  int         num_fail   = 0;
  int         acc_cnt    = 0;
  int         row_done_cnt   = 0;
  int         frame_done_cnt = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         start_idx;
  int         base;
  int         rd0;

  // Source model: every accepted byte advances the counter that generates src_data
  always @(posedge din_clk) begin
    if (src_vld && src_rdy) acc_cnt <= acc_cnt + 1;
  end

  always @(negedge din_clk) begin
    if (o_data_din_vld) got.push_back(o_data_din);
    if (row_done) row_done_cnt <= row_done_cnt + 1;
    if (frame_done) frame_done_cnt <= frame_done_cnt + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge din_clk);
    #1;
    src_data = 8'h10 + acc_cnt[7:0];
  endtask

  task automatic applyStimulus(input int rows, input int cols, input logic [7:0] pad);
    cfg_rows  = rows[7:0];
    cfg_cols  = cols[7:0];
    cfg_pad   = pad;
    src_vld   = 1'b0;
    start_idx = got.size();
    base      = acc_cnt;
    rd0       = row_done_cnt;
    start     = 1'b1;
    nextCycle();
    start     = 1'b0;
  endtask

  task automatic runFrame(input bit toggle_vld, input bit hold_en,
                          input bit poke_start, input bit stray_pe);
    int  cyc    = 0;
    int  acked  = 0;
    int  stall  = 0;
    int  fd0    = frame_done_cnt;
    bit  waiting;
    while (frame_done_cnt == fd0 && cyc < 400) begin
      waiting = (got.size() - start_idx) >= (acked + 1) * VEC;
      if (waiting) begin
        stall++;
        checkOutput("src_rdy_in_wait_pe", src_rdy, 0);
        if (stall == 3)
          checkOutput("bytes_held_in_wait_pe", got.size() - start_idx, (acked + 1) * VEC);
      end
      if (cyc == 2) checkOutput("busy_mid_frame", busy, 1);
      if (hold_en && cyc == 10) begin
        checkOutput("vld_while_en_low", o_data_din_vld, 0);
        checkOutput("rdy_while_en_low", src_rdy, 0);
      end
      src_vld     = toggle_vld ? (cyc % 2 == 0) : 1'b1;
      en          = !(hold_en && cyc >= 8 && cyc < 11);
      pe_dout_vld = (waiting && stall == 3) || (stray_pe && cyc == 5);
      if (waiting && stall == 3) begin
        acked++;
        stall = 0;
      end
      start = poke_start && cyc == 6;
      if (poke_start && cyc == 6) cfg_rows = 8'd5;
      nextCycle();
      cyc++;
    end
    pe_dout_vld = 1'b0;
    src_vld     = 1'b0;
    en          = 1'b1;
    start       = 1'b0;
    checkOutput("frame_done_seen", frame_done_cnt != fd0, 1);
    checkOutput("busy_after_frame", busy, 0);
  endtask

  // Expected stream: padL zeros, source bytes, padR zeros per row, then zero fill to a vector
  task automatic compareFrame(input string name, input int rows, input int cols,
                              input int padl, input int padr, input int exp_total);
    int k = 0;
    exp_q.delete();
    for (int r = 0; r < rows; r++) begin
      for (int p = 0; p < padl; p++) exp_q.push_back(8'h00);
      for (int c = 0; c < cols; c++) begin
        exp_q.push_back(8'(8'h10 + base + k));
        k++;
      end
      for (int p = 0; p < padr; p++) exp_q.push_back(8'h00);
    end
    while (exp_q.size() % VEC != 0) exp_q.push_back(8'h00);
    checkOutput({name, "_byte_count"}, got.size() - start_idx, exp_total);
    checkOutput({name, "_row_done_count"}, row_done_cnt - rd0, rows);
    for (int i = 0; i < exp_total && i < got.size() - start_idx; i++)
      checkOutput($sformatf("%s_byte%0d", name, i), got[start_idx + i], exp_q[i]);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; start = 1'b0; cfg_cols = '0; cfg_rows = '0; cfg_pad = '0;
    src_data = '0; src_vld = 1'b0; pe_dout_vld = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("reset_src_rdy", src_rdy, 0);
    checkOutput("reset_vld", o_data_din_vld, 0);
    checkOutput("reset_data", o_data_din, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_row_done", row_done, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    rst_n = 1'b1;
    nextCycle();

    $display("[TB] T1 rows=1 cols=24 pad=11");
    applyStimulus(1, 24, 8'h11);
    runFrame(1'b0, 1'b0, 1'b0, 1'b0);
    compareFrame("t1", 1, 24, 1, 1, 26);

    $display("[TB] T2 rows=2 cols=10 pad=21, start poked mid-frame");
    applyStimulus(2, 10, 8'h21);
    runFrame(1'b0, 1'b0, 1'b1, 1'b0);
    compareFrame("t2", 2, 10, 2, 1, 26);
    nextCycle();
    nextCycle();
    checkOutput("t2_no_restart", busy, 0);

    $display("[TB] T3 rows=1 cols=5 pad=00");
    applyStimulus(1, 5, 8'h00);
    runFrame(1'b0, 1'b0, 1'b0, 1'b0);
    compareFrame("t3", 1, 5, 0, 0, 26);

    $display("[TB] T4 src_vld toggling, en held low, stray ack");
    applyStimulus(1, 20, 8'h11);
    runFrame(1'b1, 1'b1, 1'b0, 1'b1);
    compareFrame("t4", 1, 20, 1, 1, 26);

    $display("[TB] T5 rows=0");
    applyStimulus(0, 5, 8'h11);
    checkOutput("t5_frame_done_early", frame_done, 0);
    checkOutput("t5_busy", busy, 0);
    nextCycle();
    checkOutput("t5_frame_done_pulse", frame_done, 1);
    nextCycle();
    checkOutput("t5_frame_done_cleared", frame_done, 0);
    checkOutput("t5_no_bytes", got.size() - start_idx, 0);

    $display("[TB] T6 reset mid-frame, then T1 again");
    applyStimulus(1, 24, 8'h11);
    src_vld = 1'b1;
    repeat (5) nextCycle();
    checkOutput("t6_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_reset_vld", o_data_din_vld, 0);
    checkOutput("t6_reset_data", o_data_din, 0);
    checkOutput("t6_reset_busy", busy, 0);
    checkOutput("t6_reset_src_rdy", src_rdy, 0);
    src_vld = 1'b0;
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    applyStimulus(1, 24, 8'h11);
    runFrame(1'b0, 1'b0, 1'b0, 1'b0);
    compareFrame("t6", 1, 24, 1, 1, 26);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
